// File: rtl/snn_io_ctrl.sv
// Sequencer between the UART and the SNN core: it unpacks a 98-byte binary
// image into the 1-bit input RAM, starts the core and sends back the digit as ASCII.
module snn_io_ctrl #(
  parameter int          NUM_BYTES  = 98,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_clr_rdy,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  input  logic [9:0] core_addr,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic [3:0] digit_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_RX_WAIT   = 3'd0,
    S_UNPACK    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_CORE = 3'd3,
    S_TX        = 3'd4,
    S_TX_WAIT   = 3'd5
  } state_t;

  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  state_t     state_q, state_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] tx_data_q, tx_data_d;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RX_WAIT;
      byte_cnt_q <= 7'd0;
      bit_cnt_q  <= 3'd0;
      wr_addr_q  <= 10'd0;
      shift_q    <= 8'd0;
      digit_q    <= 4'd0;
      tx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_addr_q  <= wr_addr_d;
      shift_q    <= shift_d;
      digit_q    <= digit_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Next-state, datapath updates and strobe decode
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    wr_addr_d  = wr_addr_q;
    shift_d    = shift_q;
    digit_d    = digit_q;
    tx_data_d  = tx_data_q;
    rx_clr_rdy = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = core_addr;
    ram_data   = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;

    case (state_q)
      S_RX_WAIT: begin
        if (rx_rdy) begin
          shift_d    = rx_data;
          rx_clr_rdy = 1'b1;
          state_d    = S_UNPACK;
        end else begin
          state_d    = S_RX_WAIT;
        end
      end
      S_UNPACK: begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr_q;
        ram_data  = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        // The final pixel leaves wr_addr at 783; START clears it.
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_START;
          end else begin
            wr_addr_d = wr_addr_q + 10'd1;
            state_d   = S_RX_WAIT;
          end
        end else begin
          wr_addr_d = wr_addr_q + 10'd1;
        end
      end
      S_START: begin
        core_start = 1'b1;
        wr_addr_d  = 10'd0;
        byte_cnt_d = 7'd0;
        state_d    = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core_done) begin
          digit_d   = core_digit;
          tx_data_d = ASCII_BASE + {4'd0, core_digit};
          state_d   = S_TX;
        end else begin
          state_d   = S_WAIT_CORE;
        end
      end
      S_TX: begin
        tx_start = 1'b1;
        state_d  = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          state_d = S_RX_WAIT;
        end else begin
          state_d = S_TX_WAIT;
        end
      end
      default: begin
        state_d = S_RX_WAIT;
      end
    endcase
  end

  assign tx_data   = tx_data_q;
  assign digit_out = digit_q;
  assign busy      = (state_q != S_RX_WAIT);

endmodule

// File: tb/tb_snn_io_ctrl.sv
// Randomized self-checking bench for snn_io_ctrl; expected pixels, addresses
// and TX bytes come from a frame array and simple arithmetic.
module tb_snn_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_clr_rdy;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic [9:0] core_addr;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [3:0] digit_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // observation log gathered at the falling edge
  int cyc = 0;
  int wa_q[$];
  int wd_q[$];
  int clr_cnt = 0;
  int start_cnt = 0;
  int start_cyc = -1;
  int last_wr_cyc = -1;

  logic [7:0] frame [98];

  snn_io_ctrl #(.NUM_BYTES(98), .ASCII_BASE(8'h30)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_clr_rdy(rx_clr_rdy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .core_addr(core_addr), .core_start(core_start),
    .core_done(core_done), .core_digit(core_digit), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .digit_out(digit_out), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_we === 1'b1) begin
      wa_q.push_back(int'(ram_addr));
      wd_q.push_back(int'(ram_data));
      last_wr_cyc = cyc;
    end
    if (rx_clr_rdy === 1'b1) clr_cnt = clr_cnt + 1;
    if (core_start === 1'b1) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wa_q.delete();
    wd_q.delete();
    clr_cnt = 0;
    start_cnt = 0;
    start_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (rx_clr_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_byte_ack: rx_clr_rdy never seen for byte %h, wanted 1", b);
      rx_rdy = 1'b0;
    end else begin
      tick();
      rx_rdy = 1'b0;
    end
  endtask

  // sends frame[first..97], then checks the whole 784-pixel write log
  task automatic run_frame(input int first, input bit gaps);
    for (int k = first; k < 98; k++) begin
      if (k == 97) begin
        total++;
        if (start_cnt !== 0) begin
          bad++;
          $display("FAIL early_start: core_start count=%0d before last byte, wanted 0", start_cnt);
        end
      end
      send_byte(frame[k]);
      if (gaps) repeat ($urandom_range(0, 12)) tick();
    end
    repeat (12) tick();
    total++;
    if (wa_q.size() !== 784) begin
      bad++;
      $display("FAIL write_count: got %0d writes, wanted 784", wa_q.size());
    end
    total++;
    if (clr_cnt !== 98) begin
      bad++;
      $display("FAIL clr_count: got %0d rx_clr_rdy pulses, wanted 98", clr_cnt);
    end
    total++;
    if (start_cnt !== 1) begin
      bad++;
      $display("FAIL start_count: got %0d core_start pulses, wanted 1", start_cnt);
    end
    total++;
    if (start_cyc !== last_wr_cyc + 1) begin
      bad++;
      $display("FAIL start_latency: core_start cycle %0d, wanted %0d", start_cyc, last_wr_cyc + 1);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL wait_core_busy: busy=%b, wanted 1", busy);
    end
    for (int n = 0; n < 784 && n < wa_q.size(); n++) begin
      int expd;
      expd = (int'(frame[n / 8]) >> (n % 8)) & 1;
      total++;
      if (wa_q[n] !== n || wd_q[n] !== expd) begin
        bad++;
        $display("FAIL pixel_write: entry %0d addr=%0d data=%0d, wanted addr=%0d data=%0d",
                 n, wa_q[n], wd_q[n], n, expd);
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_addr = 10'd0;
    core_done = 1'b0; core_digit = 4'd0; tx_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || rx_clr_rdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b ram_we=%b rx_clr_rdy=%b, wanted 0 0 0", busy, ram_we, rx_clr_rdy);
    end
    total++;
    if (core_start !== 1'b0 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: core_start=%b tx_start=%b, wanted 0 0", core_start, tx_start);
    end
    total++;
    if (digit_out !== 4'd0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: digit_out=%h tx_data=%h, wanted 0 00", digit_out, tx_data);
    end
  endtask

  task automatic test_all_ones;
    for (int k = 0; k < 98; k++) frame[k] = 8'hFF;
    clear_mon();
    run_frame(0, 1'b1);
  endtask

  task automatic test_done_tx(input logic [3:0] d);
    logic [7:0] exp_tx;
    exp_tx = 8'h30 + {4'h0, d};
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    total++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL stray_tx_done: busy=%b tx_start=%b, wanted 1 0", busy, tx_start);
    end
    core_digit = d; core_done = 1'b1; tick();
    core_done = 1'b0; core_digit = 4'(~d);
    total++;
    if (tx_start !== 1'b1 || tx_data !== exp_tx || digit_out !== d) begin
      bad++;
      $display("FAIL tx_launch: tx_start=%b tx_data=%h digit_out=%h, wanted 1 %h %h",
               tx_start, tx_data, digit_out, exp_tx, d);
    end
    tick();
    total++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tx_pulse_width: tx_start=%b busy=%b, wanted 0 1", tx_start, busy);
    end
    core_done = 1'b1; tick(); core_done = 1'b0;
    total++;
    if (digit_out !== d) begin
      bad++;
      $display("FAIL stray_core_done: digit_out=%h, wanted %h", digit_out, d);
    end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    total++;
    if (busy !== 1'b0 || tx_data !== exp_tx) begin
      bad++;
      $display("FAIL tx_return: busy=%b tx_data=%h, wanted 0 %h", busy, tx_data, exp_tx);
    end
  endtask

  task automatic test_first_byte_and_back_to_back;
    frame[0] = 8'hA5;
    for (int k = 1; k < 98; k++) frame[k] = 8'($urandom_range(0, 255));
    clear_mon();
    send_byte(frame[0]);
    repeat (9) tick();
    total++;
    if (wa_q.size() !== 8 || busy !== 1'b0) begin
      bad++;
      $display("FAIL first_byte_count: writes=%0d busy=%b, wanted 8 0", wa_q.size(), busy);
    end
    for (int n = 0; n < 8 && n < wa_q.size(); n++) begin
      int expd;
      expd = (n == 0 || n == 2 || n == 5 || n == 7) ? 1 : 0;
      total++;
      if (wa_q[n] !== n || wd_q[n] !== expd) begin
        bad++;
        $display("FAIL first_byte_bits: entry %0d addr=%0d data=%0d, wanted addr=%0d data=%0d",
                 n, wa_q[n], wd_q[n], n, expd);
      end
    end
    run_frame(1, 1'b0);
  endtask

  task automatic test_mux_and_pending(input logic [3:0] d);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    clear_mon();
    rx_data = b; rx_rdy = 1'b1;
    for (int i = 0; i < 784; i++) begin
      core_addr = 10'(i);
      #1;
      total++;
      if (ram_addr !== 10'(i) || ram_we !== 1'b0) begin
        bad++;
        $display("FAIL addr_mux: ram_addr=%0d ram_we=%b, wanted %0d 0", ram_addr, ram_we, i);
        break;
      end
      tick();
    end
    core_addr = 10'd0;
    total++;
    if (clr_cnt !== 0 || wa_q.size() !== 0) begin
      bad++;
      $display("FAIL pending_ignored: clr=%0d writes=%0d, wanted 0 0", clr_cnt, wa_q.size());
    end
    core_digit = d; core_done = 1'b1; tick(); core_done = 1'b0;
    total++;
    if (tx_start !== 1'b1 || tx_data !== (8'h30 + {4'h0, d})) begin
      bad++;
      $display("FAIL pending_tx: tx_start=%b tx_data=%h, wanted 1 %h", tx_start, tx_data, 8'h30 + {4'h0, d});
    end
    tick();
    total++;
    if (rx_clr_rdy !== 1'b0 || clr_cnt !== 0) begin
      bad++;
      $display("FAIL pending_tx_wait: rx_clr_rdy=%b clr=%0d, wanted 0 0", rx_clr_rdy, clr_cnt);
    end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    total++;
    if (rx_clr_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pending_accept: rx_clr_rdy=%b busy=%b, wanted 1 0", rx_clr_rdy, busy);
    end
    tick();
    rx_rdy = 1'b0;
    repeat (9) tick();
    total++;
    if (wa_q.size() !== 8 || clr_cnt !== 1) begin
      bad++;
      $display("FAIL pending_writes: writes=%0d clr=%0d, wanted 8 1", wa_q.size(), clr_cnt);
    end
    for (int n = 0; n < 8 && n < wa_q.size(); n++) begin
      total++;
      if (wa_q[n] !== n || wd_q[n] !== ((int'(b) >> n) & 1)) begin
        bad++;
        $display("FAIL pending_bits: entry %0d addr=%0d data=%0d, wanted addr=%0d data=%0d",
                 n, wa_q[n], wd_q[n], n, (int'(b) >> n) & 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k < 50; k++) send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    tick();
    tick();
    total++;
    if (ram_we !== 1'b1) begin
      bad++;
      $display("FAIL mid_unpack: ram_we=%b before reset, wanted 1", ram_we);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    total++;
    if (ram_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_abort: ram_we=%b busy=%b, wanted 0 0", ram_we, busy);
    end
    clear_mon();
    repeat (10) tick();
    total++;
    if (wa_q.size() !== 0) begin
      bad++;
      $display("FAIL mid_reset_quiet: writes=%0d after reset, wanted 0", wa_q.size());
    end
    for (int k = 0; k < 98; k++) frame[k] = 8'($urandom_range(0, 255));
    clear_mon();
    run_frame(0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_done_tx(4'd7);
    test_first_byte_and_back_to_back();
    test_mux_and_pending(4'($urandom_range(0, 9)));
    test_reset_mid();
    test_done_tx(4'($urandom_range(0, 15)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
